// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period / high-time capture block.
// Holds the FSM state enum, default counter width and timeout, and averaging depth.
// No logic; imported by pwm_capture and pwm_sync_edge.
package pwm_capture_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 65535;
  localparam int AVG_DEPTH   = 4;
  localparam int AVG_SHIFT   = $clog2(AVG_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no reference rising edge yet
    ST_HIGH_PH = 2'd1,  // high phase of the current period
    ST_LOW_PH  = 2'd2   // low phase, waiting for the closing rising edge
  } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM line plus rising-edge detector.
// Latency: level and rise are available 2 cycles after the input transition.
// No backpressure; free-running every cycle.
module pwm_sync_edge
  import pwm_capture_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_q1;
  logic r_q2;

  // Synchronizer chain; both stages cleared by reset so no spurious edge history survives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_async;
      r_q2 <= r_q1;
    end
  end

  assign o_level = r_q1;
  assign o_rise  = r_q1 & ~r_q2;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time between consecutive rising edges; flags a stuck line.
// Latency: PERIOD/HIGH/VALID update 1 cycle after the closing edge is detected (3 cycles after the pin).
// No backpressure; VALID is a single-cycle pulse. Optional PWM_CAPTURE_AVG_EN averages 4 periods.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_stuck,
  output logic             o_stuck_lvl
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_level;
  logic             w_rise;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] w_per_nxt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic             w_done;
  logic             w_tmo;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_stuck;
  logic             r_stuck_lvl;

  pwm_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Next-state and counter update; the timeout compare keeps both counters below 2^CNT_W
  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per;
    w_hi_nxt    = r_hi;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH_PH;
          w_per_nxt   = ONE;
          w_hi_nxt    = ONE;
        end
      end
      ST_HIGH_PH: begin
        if (r_per == TMO) begin
          w_state_nxt = ST_IDLE;
          w_tmo       = 1'b1;
          w_per_nxt   = '0;
          w_hi_nxt    = '0;
        end else if (w_level) begin
          w_per_nxt = r_per + ONE;
          w_hi_nxt  = r_hi + ONE;
        end else begin
          w_state_nxt = ST_LOW_PH;
          w_per_nxt   = r_per + ONE;
        end
      end
      ST_LOW_PH: begin
        // A closing edge wins over a simultaneous timeout: the period is complete at exactly TIMEOUT
        if (w_rise) begin
          w_state_nxt = ST_HIGH_PH;
          w_done      = 1'b1;
          w_per_nxt   = ONE;
          w_hi_nxt    = ONE;
        end else if (r_per == TMO) begin
          w_state_nxt = ST_IDLE;
          w_tmo       = 1'b1;
          w_per_nxt   = '0;
          w_hi_nxt    = '0;
        end else begin
          w_per_nxt = r_per + ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_per_nxt   = '0;
        w_hi_nxt    = '0;
      end
    endcase
  end

  // State and measurement counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_per   <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_per   <= w_per_nxt;
      r_hi    <= w_hi_nxt;
    end
  end

`ifdef PWM_CAPTURE_AVG_EN
  localparam int ACC_W = CNT_W + AVG_SHIFT;

  logic [ACC_W-1:0]     r_acc_p;
  logic [ACC_W-1:0]     r_acc_h;
  logic [AVG_SHIFT-1:0] r_tally;
  logic [ACC_W-1:0]     w_sum_p;
  logic [ACC_W-1:0]     w_sum_h;
  logic [CNT_W-1:0]     w_avg_p;
  logic [CNT_W-1:0]     w_avg_h;
  logic                 w_avg_last;

  assign w_sum_p    = r_acc_p + ACC_W'(r_per);
  assign w_sum_h    = r_acc_h + ACC_W'(r_hi);
  assign w_avg_p    = CNT_W'(w_sum_p >> AVG_SHIFT);
  assign w_avg_h    = CNT_W'(w_sum_h >> AVG_SHIFT);
  assign w_avg_last = (r_tally == AVG_SHIFT'(AVG_DEPTH - 1));

  // Accumulate complete periods; a timeout discards the partial group
  always_ff @(posedge i_clk) begin
    if (i_rst || w_tmo) begin
      r_acc_p <= '0;
      r_acc_h <= '0;
      r_tally <= '0;
    end else if (w_done) begin
      if (w_avg_last) begin
        r_acc_p <= '0;
        r_acc_h <= '0;
        r_tally <= '0;
      end else begin
        r_acc_p <= w_sum_p;
        r_acc_h <= w_sum_h;
        r_tally <= r_tally + AVG_SHIFT'(1);
      end
    end
  end
`endif

  // Output registers: measurement publish with VALID pulse, stuck flag and level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
      r_stuck_lvl <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tmo) begin
        r_stuck     <= 1'b1;
        r_stuck_lvl <= w_level;
      end else if (w_rise && (r_state == ST_IDLE)) begin
        r_stuck <= 1'b0;
      end
`ifdef PWM_CAPTURE_AVG_EN
      if (w_done && w_avg_last) begin
        r_period <= w_avg_p;
        r_high   <= w_avg_h;
        r_valid  <= 1'b1;
      end
`else
      if (w_done) begin
        r_period <= r_per;
        r_high   <= r_hi;
        r_valid  <= 1'b1;
      end
`endif
    end
  end

  assign o_period    = r_period;
  assign o_high      = r_high;
  assign o_valid     = r_valid;
  assign o_stuck     = r_stuck;
  assign o_stuck_lvl = r_stuck_lvl;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535: cycles without a rising edge before the stuck condition is declared; SHALL be in 2..2^CNT_W-1.
REQ-003 CLK  in  1  sole clock; all logic on posedge CLK.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 PWM_IN  in  1  asynchronous PWM waveform, e.g. an LED drive line.
REQ-006 PERIOD  out  CNT_W  cycles between the last two rising edges.
REQ-007 HIGH  out  CNT_W  cycles PWM_IN was high within that period.
REQ-008 VALID  out  1  one-cycle pulse when PERIOD/HIGH update.
REQ-009 STUCK  out  1  no rising edge seen within TIMEOUT cycles.
REQ-010 STUCK_LVL  out  1  synchronized PWM_IN level when STUCK was set.

Function
REQ-011 PWM_IN SHALL pass a 2-flop synchronizer; the rising edge is sync_q1=1 and sync_q2=0; edge-to-state latency is 2 CLK.
REQ-012 FSM states SHALL be IDLE (no reference edge), HIGH_PH, LOW_PH.
REQ-013 IDLE -> HIGH_PH on a rising edge: period counter loads 1, high counter loads 1, no VALID.
REQ-014 HIGH_PH: each cycle both counters increment while the level is high; on the first low level go to LOW_PH, period counter increments.
REQ-015 LOW_PH: period counter increments each cycle; on a rising edge latch PERIOD=period counter and HIGH=high counter, pulse VALID for one cycle, reload both counters to 1, go to HIGH_PH.
REQ-016 A rising edge detected in HIGH_PH is impossible by construction; no other transitions exist.
REQ-017 Minimum measurable period is 2 cycles (1 high, 1 low); shorter pulses are not required to be captured.
REQ-018 Timeout: when the period counter reaches TIMEOUT in HIGH_PH or LOW_PH, go to IDLE, set STUCK=1, set STUCK_LVL=current level; PERIOD/HIGH hold, no VALID.
REQ-019 STUCK SHALL clear on the next rising edge, which then behaves as REQ-013.
REQ-020 Counters SHALL never wrap; TIMEOUT bounds them below 2^CNT_W.
REQ-021 VALID and the PERIOD/HIGH update SHALL occur in the same cycle, one cycle after the edge is detected.

Reset
REQ-022 While RST=1: state IDLE; synchronizer flops, counters, PERIOD, HIGH, VALID, STUCK and STUCK_LVL = 0.
REQ-023 RST asserted mid-period discards the partial measurement; the first rising edge after release produces no VALID.

Configuration
REQ-024 Macro PWM_CAPTURE_AVG_EN: when defined, sum four consecutive complete periods in CNT_W+2-bit accumulators; on the 4th, PERIOD=sum>>2 and HIGH=sum>>2 (truncated), VALID pulses once per 4 periods.
REQ-025 With PWM_CAPTURE_AVG_EN, timeout or reset SHALL clear the accumulators and the period tally.
REQ-026 Without the macro, every complete period updates the outputs per REQ-015 and no accumulator logic exists.

Structure
REQ-027 Package pwm_capture_pkg SHALL hold the FSM state enum, the default CNT_W and TIMEOUT, and the averaging depth constant (4).
REQ-028 Sub-module pwm_sync_edge SHALL implement the 2-flop synchronizer and rising-edge detector, outputting the level and a rise pulse.

Verification
REQ-029 Period 10 and high 3, repeated -> from the 2nd rising edge, one VALID per period with PERIOD=10 and HIGH=3.
REQ-030 Minimum waveform (1 high, 1 low) -> PERIOD=2, HIGH=1 on each VALID.
REQ-031 TIMEOUT=100, PWM_IN held high after one edge -> STUCK=1 and STUCK_LVL=1 at 100 counted cycles, no VALID; the next edge clears STUCK.
REQ-032 RST pulsed mid-period with period 10 / high 3 -> all outputs 0; first post-reset edge gives no VALID, the second gives PERIOD=10, HIGH=3.
REQ-033 PWM_CAPTURE_AVG_EN defined; periods 10, 10, 12, 12 with highs 2, 4, 2, 4 -> a single VALID after the 4th period with PERIOD=11, HIGH=3.
REQ-034 Period change from 10 to 20, high 5 -> the first VALID after the change reports PERIOD=20 and HIGH=5 exactly.
